// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared types and constants for the SDRAM frame address generator.
//   t_req_addr         : request word address at the default address width
//   t_rd_state         : read-request FSM state encoding
//   bursts_per_line()  : bursts needed to cover one display line
//   frame_words()      : words held by one complete frame
//   c_bursts_per_line  : bursts per line at the default geometry
//   c_frame_words      : words per frame at the default geometry
// The helper functions are evaluated at elaboration time only, so the
// product in frame_words() never becomes a hardware multiplier.
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam int c_def_burst_size  = 8;
    localparam int c_def_line_words  = 640;
    localparam int c_def_frame_lines = 480;
    localparam int c_def_addrw       = 24;
    localparam int c_def_buf_stride  = 524288;

    typedef logic [c_def_addrw-1:0] t_req_addr;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } t_rd_state;

    function automatic int bursts_per_line(input int line_words, input int burst_size);
        return line_words / burst_size;
    endfunction

    function automatic int frame_words(input int line_words, input int frame_lines);
        return line_words * frame_lines;
    endfunction

    localparam int c_bursts_per_line = bursts_per_line(c_def_line_words, c_def_burst_size);
    localparam int c_frame_words     = frame_words(c_def_line_words, c_def_frame_lines);

endpackage

// File: rtl/sdram_frame_addr_gen.sv
// -----------------------------------------------------------------------------
// sdram_frame_addr_gen
// Address/request scheduler in the SDRAM clock domain. The write side walks a
// camera frame burst by burst into one of two ping-pong buffers; the read side
// issues one line worth of read-burst requests per VGA line from the buffer
// that was most recently completed.
//
// Ports:
//   i_clk, i_rst        : SDRAM clock, synchronous active-high reset
//   i_new_frame         : VGA frame start pulse
//   i_new_line          : VGA line start pulse
//   i_wr_sof            : camera frame start pulse
//   i_wr_burst_fire     : controller accepted a write burst
//   o_wr_addr           : address of the next write burst
//   o_rd_req_valid      : read request valid
//   o_rd_req_addr       : read burst address (stable until accepted)
//   i_rd_req_ready      : read request FIFO ready
//   o_wr_buf, o_rd_buf  : buffer currently written / read
//   o_frame_avail       : at least one complete frame written
//   o_rd_overrun        : sticky, a line started before the previous finished
//   o_wr_abort          : sticky, camera restarted a frame part way through
// -----------------------------------------------------------------------------
module sdram_frame_addr_gen
    import sdram_pkg::*;
#(
    parameter int p_burst_size  = c_def_burst_size,
    parameter int p_line_words  = c_def_line_words,
    parameter int p_frame_lines = c_def_frame_lines,
    parameter int p_addrw       = c_def_addrw,
    parameter int p_buf_stride  = c_def_buf_stride
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_new_frame,
    input  logic               i_new_line,
    input  logic               i_wr_sof,
    input  logic               i_wr_burst_fire,
    output logic [p_addrw-1:0] o_wr_addr,
    output logic               o_rd_req_valid,
    output logic [p_addrw-1:0] o_rd_req_addr,
    input  logic               i_rd_req_ready,
    output logic               o_wr_buf,
    output logic               o_rd_buf,
    output logic               o_frame_avail,
    output logic               o_rd_overrun,
    output logic               o_wr_abort
);

    localparam int c_bursts = bursts_per_line(p_line_words, p_burst_size);
    localparam int c_words  = frame_words(p_line_words, p_frame_lines);
    localparam int c_lw     = $clog2(p_frame_lines + 1);
    localparam int c_cw     = $clog2(c_bursts + 1);

    localparam logic [p_addrw-1:0] c_burst_inc = p_addrw'(p_burst_size);
    localparam logic [p_addrw-1:0] c_line_inc  = p_addrw'(p_line_words);
    localparam logic [p_addrw-1:0] c_frame_end = p_addrw'(c_words);
    localparam logic [p_addrw-1:0] c_stride    = p_addrw'(p_buf_stride);
    localparam logic [c_lw-1:0]    c_num_lines = c_lw'(p_frame_lines);
    localparam logic [c_lw-1:0]    c_one_line  = c_lw'(1);
    localparam logic [c_cw-1:0]    c_last_bst  = c_cw'(c_bursts - 1);
    localparam logic [c_cw-1:0]    c_one_bst   = c_cw'(1);

    function automatic logic [p_addrw-1:0] buf_base(input logic b);
        return b ? c_stride : '0;
    endfunction

    // write side state
    logic [p_addrw-1:0] wr_off;
    logic [p_addrw-1:0] wr_off_nxt;
    logic [p_addrw-1:0] wr_sum;
    logic               wr_buf_nxt;
    logic               wr_frame_done;
    logic               wr_abort_evt;

    // read side state
    t_rd_state          rd_state;
    logic [c_lw-1:0]    rd_line;
    logic [p_addrw-1:0] rd_line_base;
    logic [c_cw-1:0]    burst_cnt;
    logic               swap_pending;
    logic [c_lw-1:0]    eff_line;
    logic [p_addrw-1:0] eff_base;
    logic               eff_buf;
    logic               line_accept;
    logic               rd_fire;

    // Next write offset/buffer. A camera frame start always restarts the
    // offset, and a burst accepted in the same cycle already belongs to the
    // new frame, so the offset lands on one burst rather than zero.
    always_comb begin
        wr_sum        = wr_off + c_burst_inc;
        wr_off_nxt    = wr_off;
        wr_buf_nxt    = o_wr_buf;
        wr_frame_done = 1'b0;
        wr_abort_evt  = 1'b0;
        if (i_wr_sof) begin
            wr_abort_evt = (wr_off != '0);
            wr_off_nxt   = i_wr_burst_fire ? c_burst_inc : '0;
        end else if (i_wr_burst_fire) begin
            if (wr_sum == c_frame_end) begin
                wr_off_nxt    = '0;
                wr_buf_nxt    = ~o_wr_buf;
                wr_frame_done = 1'b1;
            end else begin
                wr_off_nxt = wr_sum;
            end
        end
    end

    // Write pointer register. The output address is precomputed from the
    // next-state values so it is valid one cycle after every update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_off        <= '0;
            o_wr_buf      <= 1'b0;
            o_wr_addr     <= '0;
            o_frame_avail <= 1'b0;
            o_wr_abort    <= 1'b0;
        end else begin
            wr_off    <= wr_off_nxt;
            o_wr_buf  <= wr_buf_nxt;
            o_wr_addr <= buf_base(wr_buf_nxt) + wr_off_nxt;
            if (wr_frame_done) begin
                o_frame_avail <= 1'b1;
            end
            if (wr_abort_evt) begin
                o_wr_abort <= 1'b1;
            end
        end
    end

    // Frame start is applied before line start: when both pulse together,
    // the line counter, line base and read buffer seen by the line logic are
    // the post-frame-start values.
    always_comb begin
        eff_line    = i_new_frame ? '0 : rd_line;
        eff_base    = i_new_frame ? '0 : rd_line_base;
        eff_buf     = (i_new_frame && swap_pending) ? ~o_wr_buf : o_rd_buf;
        line_accept = i_new_line && (eff_line < c_num_lines);
        rd_fire     = (rd_state == ISSUE) && i_rd_req_ready;
    end

    // Read pointer and request FSM. An accepted line start always restarts
    // the burst sequence, even mid-line, which drops the unsent requests of
    // the previous line.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_state      <= IDLE;
            rd_line       <= '0;
            rd_line_base  <= '0;
            burst_cnt     <= '0;
            o_rd_req_addr <= '0;
            o_rd_buf      <= 1'b1;
            swap_pending  <= 1'b0;
            o_rd_overrun  <= 1'b0;
        end else begin
            o_rd_buf     <= eff_buf;
            swap_pending <= (swap_pending && !i_new_frame) || wr_frame_done;
            if (i_new_line && (rd_state == ISSUE)) begin
                o_rd_overrun <= 1'b1;
            end
            if (line_accept) begin
                rd_state      <= ISSUE;
                o_rd_req_addr <= buf_base(eff_buf) + eff_base;
                burst_cnt     <= '0;
                rd_line       <= eff_line + c_one_line;
                rd_line_base  <= eff_base + c_line_inc;
            end else begin
                rd_line      <= eff_line;
                rd_line_base <= eff_base;
                if (rd_fire) begin
                    o_rd_req_addr <= o_rd_req_addr + c_burst_inc;
                    burst_cnt     <= burst_cnt + c_one_bst;
                    if (burst_cnt == c_last_bst) begin
                        rd_state <= IDLE;
                    end
                end
            end
        end
    end

    assign o_rd_req_valid = (rd_state == ISSUE);

endmodule
